// File: rtl/rvv_backend_dispatch_opr_ctrl_pkg.sv
`default_nettype none
// rvv_backend_dispatch_opr_ctrl_pkg: shared widths, operand slot encoding and
// bundle types for the dispatch operand-fetch controller.
package rvv_backend_dispatch_opr_ctrl_pkg;

  localparam int VLEN            = 128;
  localparam int ROB_DEPTH       = 8;
  localparam int NUM_VRF_RD_PORT = 2;
  localparam int NUM_OPR         = 4;

  localparam logic [1:0] OPR_VS1 = 2'd0;
  localparam logic [1:0] OPR_VS2 = 2'd1;
  localparam logic [1:0] OPR_VD  = 2'd2;
  localparam logic [1:0] OPR_V0  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2
  } OPR_CTRL_STATE_e;

  // Field order puts vs1 at the LSB so the struct maps onto [OPR slot] arrays.
  typedef struct packed {
    logic [ROB_DEPTH-1:0] v0_hit;
    logic [ROB_DEPTH-1:0] vd_hit;
    logic [ROB_DEPTH-1:0] vs2_hit;
    logic [ROB_DEPTH-1:0] vs1_hit;
  } RAW_UOP_ROB_t;

  typedef struct packed {
    logic [VLEN-1:0] v0;
    logic [VLEN-1:0] vd;
    logic [VLEN-1:0] vs2;
    logic [VLEN-1:0] vs1;
  } UOP_OPN_t;

endpackage
`default_nettype wire

// File: rtl/rvv_backend_dispatch_opr_pick2.sv
`default_nettype none
// rvv_backend_dispatch_opr_pick2: returns the indices of the lowest two set
// bits of a 4-bit request vector, with a valid bit for each.
module rvv_backend_dispatch_opr_pick2 (
  input  logic [3:0] req_i,
  output logic [1:0] idx0_o,
  output logic [1:0] idx1_o,
  output logic       vld0_o,
  output logic       vld1_o
);

  logic [1:0] idx0, idx1;
  logic       vld0, vld1;

  always_comb begin
    idx0 = '0;
    idx1 = '0;
    vld0 = 1'b0;
    vld1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (req_i[i]) begin
        if (!vld0) begin
          vld0 = 1'b1;
          idx0 = 2'(i);
        end else if (!vld1) begin
          vld1 = 1'b1;
          idx1 = 2'(i);
        end
      end
    end
  end

  assign idx0_o = idx0;
  assign idx1_o = idx1;
  assign vld0_o = vld0;
  assign vld1_o = vld1;

endmodule
`default_nettype wire

// File: rtl/rvv_backend_dispatch_opr_ctrl.sv
`default_nettype none
// rvv_backend_dispatch_opr_ctrl: sequences VRF operand reads for one uop over two
// read ports and holds it until all RAW-hit ROB entries have produced data.
module rvv_backend_dispatch_opr_ctrl
  import rvv_backend_dispatch_opr_ctrl_pkg::*;
(
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      trap_flush_i,
  input  logic                                      uop_valid_i,
  output logic                                      uop_ready_o,
  input  logic [3:0]                                uop_rd_en_i,
  input  logic [4:0]                                uop_vs1_idx_i,
  input  logic [4:0]                                uop_vs2_idx_i,
  input  logic [4:0]                                uop_vd_idx_i,
  input  RAW_UOP_ROB_t                              raw_uop_rob_i,
  input  logic [ROB_DEPTH-1:0]                      rob_done_i,
  input  logic [ROB_DEPTH-1:0]                      rob_retire_i,
  output logic [NUM_VRF_RD_PORT-1:0]                vrf_rd_en_o,
  output logic [NUM_VRF_RD_PORT-1:0][4:0]           vrf_rd_addr_o,
  input  logic [NUM_VRF_RD_PORT-1:0][VLEN-1:0]      vrf_rd_data_i,
  output logic                                      opn_valid_o,
  input  logic                                      opn_ready_i,
  output UOP_OPN_t                                  vrf_byp_o,
  output RAW_UOP_ROB_t                              raw_uop_rob_q_o
);

  OPR_CTRL_STATE_e                        state_q, state_d;
  logic [NUM_OPR-1:0]                     need_rd_q, need_rd_d;
  logic [NUM_OPR-1:0]                     rd_en_q, rd_en_d;
  logic [NUM_VRF_RD_PORT-1:0]             pend_q, pend_d;
  logic [NUM_VRF_RD_PORT-1:0][1:0]        pend_slot_q, pend_slot_d;
  logic [NUM_OPR-1:0][4:0]                idx_q, idx_d;
  logic [NUM_OPR-1:0][ROB_DEPTH-1:0]      hit_q, hit_d;
  logic [NUM_OPR-1:0][VLEN-1:0]           byp_q, byp_d;

  logic [1:0]           pick_idx0, pick_idx1;
  logic                 pick_vld0, pick_vld1;
  logic [ROB_DEPTH-1:0] hit_any;
  logic                 all_done, fire, accept;

  rvv_backend_dispatch_opr_pick2 u_pick2 (
    .req_i  (need_rd_q),
    .idx0_o (pick_idx0),
    .idx1_o (pick_idx1),
    .vld0_o (pick_vld0),
    .vld1_o (pick_vld1)
  );

  assign vrf_rd_en_o      = (state_q == READ) ? {pick_vld1, pick_vld0} : '0;
  assign vrf_rd_addr_o[0] = vrf_rd_en_o[0] ? idx_q[pick_idx0] : '0;
  assign vrf_rd_addr_o[1] = vrf_rd_en_o[1] ? idx_q[pick_idx1] : '0;

  assign hit_any     = hit_q[0] | hit_q[1] | hit_q[2] | hit_q[3];
  assign all_done    = &(~hit_any | rob_done_i);
  assign uop_ready_o = (state_q == IDLE) & ~trap_flush_i;
  assign opn_valid_o = (state_q == HOLD) & ~|pend_q & ~|need_rd_q & all_done & ~trap_flush_i;
  assign fire        = opn_valid_o & opn_ready_i;
  assign accept      = uop_valid_i & uop_ready_o;

  assign vrf_byp_o       = byp_q;
  assign raw_uop_rob_q_o = hit_q;

  always_comb begin
    state_d     = state_q;
    need_rd_d   = need_rd_q;
    rd_en_d     = rd_en_q;
    pend_d      = '0;
    pend_slot_d = pend_slot_q;
    idx_d       = idx_q;
    hit_d       = hit_q;
    byp_d       = byp_q;

    for (int p = 0; p < NUM_VRF_RD_PORT; p++) begin
      if (pend_q[p]) byp_d[pend_slot_q[p]] = vrf_rd_data_i[p];
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          idx_d[OPR_VS1] = uop_vs1_idx_i;
          idx_d[OPR_VS2] = uop_vs2_idx_i;
          idx_d[OPR_VD]  = uop_vd_idx_i;
          idx_d[OPR_V0]  = '0;
          hit_d          = raw_uop_rob_i;
          need_rd_d      = uop_rd_en_i;
          rd_en_d        = uop_rd_en_i;
          byp_d          = '0;
          state_d        = (uop_rd_en_i != '0) ? READ : HOLD;
        end
      end
      READ: begin
        if (vrf_rd_en_o[0]) need_rd_d[pick_idx0] = 1'b0;
        if (vrf_rd_en_o[1]) need_rd_d[pick_idx1] = 1'b0;
        pend_d      = vrf_rd_en_o;
        pend_slot_d = {pick_idx1, pick_idx0};
      end
      HOLD: begin
        if (fire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A retiring hit entry moves its data into the VRF, so that operand must be re-read.
    if ((state_q != IDLE) && !fire) begin
      for (int k = 0; k < NUM_OPR; k++) begin
        if (|(hit_q[k] & rob_retire_i)) begin
          hit_d[k] = hit_q[k] & ~rob_retire_i;
          if (rd_en_q[k]) need_rd_d[k] = 1'b1;
        end
      end
      state_d = (need_rd_d != '0) ? READ : HOLD;
    end

    if (trap_flush_i) begin
      state_d   = IDLE;
      need_rd_d = '0;
      pend_d    = '0;
      hit_d     = '0;
      byp_d     = byp_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      need_rd_q   <= '0;
      rd_en_q     <= '0;
      pend_q      <= '0;
      pend_slot_q <= '0;
      idx_q       <= '0;
      hit_q       <= '0;
      byp_q       <= '0;
    end else begin
      state_q     <= state_d;
      need_rd_q   <= need_rd_d;
      rd_en_q     <= rd_en_d;
      pend_q      <= pend_d;
      pend_slot_q <= pend_slot_d;
      idx_q       <= idx_d;
      hit_q       <= hit_d;
      byp_q       <= byp_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rvv_backend_dispatch_opr_ctrl.sv
`default_nettype none
// tb_rvv_backend_dispatch_opr_ctrl: directed stimulus with a queued scoreboard
// for VRF read requests and operand fires, plus direct state checks.
module tb_rvv_backend_dispatch_opr_ctrl;
  import rvv_backend_dispatch_opr_ctrl_pkg::*;

  logic                            clk;
  logic                            rst_n;
  logic                            trap_flush;
  logic                            uop_valid;
  logic                            uop_ready;
  logic [3:0]                      uop_rd_en;
  logic [4:0]                      uop_vs1_idx, uop_vs2_idx, uop_vd_idx;
  RAW_UOP_ROB_t                    raw_uop_rob;
  logic [ROB_DEPTH-1:0]            rob_done, rob_retire;
  logic [1:0]                      vrf_rd_en;
  logic [1:0][4:0]                 vrf_rd_addr;
  logic [1:0][VLEN-1:0]            vrf_rd_data;
  logic                            opn_valid;
  logic                            opn_ready;
  UOP_OPN_t                        vrf_byp;
  RAW_UOP_ROB_t                    raw_uop_rob_q;

  rvv_backend_dispatch_opr_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .trap_flush_i    (trap_flush),
    .uop_valid_i     (uop_valid),
    .uop_ready_o     (uop_ready),
    .uop_rd_en_i     (uop_rd_en),
    .uop_vs1_idx_i   (uop_vs1_idx),
    .uop_vs2_idx_i   (uop_vs2_idx),
    .uop_vd_idx_i    (uop_vd_idx),
    .raw_uop_rob_i   (raw_uop_rob),
    .rob_done_i      (rob_done),
    .rob_retire_i    (rob_retire),
    .vrf_rd_en_o     (vrf_rd_en),
    .vrf_rd_addr_o   (vrf_rd_addr),
    .vrf_rd_data_i   (vrf_rd_data),
    .opn_valid_o     (opn_valid),
    .opn_ready_i     (opn_ready),
    .vrf_byp_o       (vrf_byp),
    .raw_uop_rob_q_o (raw_uop_rob_q)
  );

  typedef struct { int cyc; int port; int addr; } rd_exp_t;
  typedef struct { int cyc; UOP_OPN_t byp; RAW_UOP_ROB_t hits; } fire_exp_t;

  rd_exp_t   rq[$];
  fire_exp_t fq[$];
  int        n_tests = 0;
  int        n_fail  = 0;
  int        cyc     = 0;
  int        c0      = 0;
  int        gen     = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Data encodes the register index and a generation tag so stale reads are visible.
  function automatic logic [VLEN-1:0] vdata(input int a, input int g);
    logic [31:0] w;
    w = {g[7:0], 19'h5A5A5, a[4:0]};
    return {(VLEN/32){w}};
  endfunction

  always @(posedge clk) begin
    for (int p = 0; p < 2; p++)
      vrf_rd_data[p] <= vrf_rd_en[p] ? vdata(int'(vrf_rd_addr[p]), gen) : {VLEN{1'b1}};
  end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int p = 0; p < 2; p++) begin
        if (vrf_rd_en[p]) begin
          if (rq.size() == 0) chk("rd_unexpected", 1, 0);
          else begin
            rd_exp_t r;
            r = rq.pop_front();
            chk("rd_cycle", cyc, r.cyc);
            chk("rd_port", p, r.port);
            chk("rd_addr", vrf_rd_addr[p], r.addr);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && opn_valid && opn_ready) begin
      if (fq.size() == 0) chk("fire_unexpected", 1, 0);
      else begin
        fire_exp_t f;
        f = fq.pop_front();
        chk("fire_cycle", cyc, f.cyc);
        chk("fire_byp", vrf_byp, f.byp);
        chk("fire_hits", raw_uop_rob_q, f.hits);
      end
    end
  end

  task automatic goto(input int k);
    while (cyc < c0 + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_rd(input int k, input int p, input int a);
    rd_exp_t r;
    r.cyc = c0 + k; r.port = p; r.addr = a;
    rq.push_back(r);
  endtask

  task automatic exp_fire(input int k, input UOP_OPN_t b, input RAW_UOP_ROB_t h);
    fire_exp_t f;
    f.cyc = c0 + k; f.byp = b; f.hits = h;
    fq.push_back(f);
  endtask

  task automatic issue(input logic [3:0] en, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [4:0] d, input RAW_UOP_ROB_t h);
    int guard;
    guard       = 0;
    uop_rd_en   = en;
    uop_vs1_idx = s1;
    uop_vs2_idx = s2;
    uop_vd_idx  = d;
    raw_uop_rob = h;
    uop_valid   = 1'b1;
    @(negedge clk);
    while (!uop_ready && guard < 50) begin
      guard++;
      @(negedge clk);
    end
    if (!uop_ready) chk("accept_timeout", 0, 1);
    c0 = cyc;
    @(posedge clk);
    #1;
    uop_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    UOP_OPN_t     e;
    RAW_UOP_ROB_t h;
    rst_n = 1'b0; trap_flush = 1'b0; uop_valid = 1'b0; opn_ready = 1'b1;
    uop_rd_en = '0; uop_vs1_idx = '0; uop_vs2_idx = '0; uop_vd_idx = '0;
    raw_uop_rob = '0; rob_done = '0; rob_retire = '0;

    repeat (2) @(negedge clk);
    chk("rst_uop_ready", uop_ready, 1);
    chk("rst_opn_valid", opn_valid, 0);
    chk("rst_rd_en", vrf_rd_en, 0);
    chk("rst_rd_addr", vrf_rd_addr, 0);
    chk("rst_byp", vrf_byp, 0);
    chk("rst_hits", raw_uop_rob_q, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // vs1/vs2 only: reads in cycle 1, operands in cycle 3
    gen = 1; h = '0;
    issue(4'b0011, 5'd5, 5'd9, 5'd3, h);
    exp_rd(1, 0, 5); exp_rd(1, 1, 9);
    e = '0; e.vs1 = vdata(5, 1); e.vs2 = vdata(9, 1);
    exp_fire(3, e, h);
    goto(5);

    // all four operands: two read cycles, v0 from index 0, operands in cycle 4
    gen = 2;
    issue(4'b1111, 5'd1, 5'd2, 5'd30, h);
    exp_rd(1, 0, 1); exp_rd(1, 1, 2); exp_rd(2, 0, 30); exp_rd(2, 1, 0);
    e.vs1 = vdata(1, 2); e.vs2 = vdata(2, 2); e.vd = vdata(30, 2); e.v0 = vdata(0, 2);
    exp_fire(4, e, h);
    goto(6);

    // no operands: valid in cycle 1, bundle cleared from the previous uop
    issue(4'b0000, 5'd7, 5'd8, 5'd9, h);
    e = '0;
    exp_fire(1, e, h);
    goto(3);

    // vs2 hit on ROB entry 2, done only from cycle 6
    gen = 3; h = '0; h.vs2_hit = 8'h04;
    issue(4'b0010, 5'd0, 5'd7, 5'd0, h);
    exp_rd(1, 0, 7);
    e = '0; e.vs2 = vdata(7, 3);
    exp_fire(6, e, h);
    goto(6); rob_done = 8'h04;
    goto(7); rob_done = '0;
    goto(8);

    // entry 2 retires in cycle 5: hit dropped, vs2 re-read in cycle 6 with new data
    issue(4'b0010, 5'd0, 5'd7, 5'd0, h);
    exp_rd(1, 0, 7); exp_rd(6, 0, 7);
    e = '0; e.vs2 = vdata(7, 4);
    exp_fire(8, e, '0);
    goto(5); rob_retire = 8'h04; gen = 4;
    goto(6); rob_retire = '0;
    goto(10);

    // retire of a hit on an operand not read: hit dropped, no re-read
    gen = 5; h = '0; h.vd_hit = 8'h10;
    issue(4'b0001, 5'd4, 5'd0, 5'd0, h);
    exp_rd(1, 0, 4);
    e = '0; e.vs1 = vdata(4, 5);
    exp_fire(4, e, '0);
    goto(3); rob_retire = 8'h10;
    goto(4); rob_retire = '0;
    goto(6);

    // consumer stalls for 10 cycles: outputs must hold
    gen = 6; h = '0; opn_ready = 1'b0;
    issue(4'b0101, 5'd11, 5'd0, 5'd12, h);
    exp_rd(1, 0, 11); exp_rd(1, 1, 12);
    e = '0; e.vs1 = vdata(11, 6); e.vd = vdata(12, 6);
    for (int k = 3; k < 13; k++) begin
      goto(k);
      @(negedge clk);
      chk("hold_valid", opn_valid, 1);
      chk("hold_uop_ready", uop_ready, 0);
      chk("hold_byp", vrf_byp, e);
    end
    goto(13); opn_ready = 1'b1;
    exp_fire(13, e, h);
    goto(14);
    @(negedge clk);
    chk("post_fire_ready", uop_ready, 1);
    goto(15);

    // trap_flush while a read is in flight
    gen = 7;
    issue(4'b0001, 5'd6, 5'd0, 5'd0, h);
    exp_rd(1, 0, 6);
    goto(2); trap_flush = 1'b1;
    @(negedge clk);
    chk("flush_valid", opn_valid, 0);
    goto(3); trap_flush = 1'b0;
    @(negedge clk);
    chk("flush_idle_ready", uop_ready, 1);
    chk("flush_opn_valid", opn_valid, 0);
    chk("flush_byp", vrf_byp, 0);
    chk("flush_rd_en", vrf_rd_en, 0);
    goto(5);
    @(negedge clk);
    chk("flush_byp_later", vrf_byp, 0);
    goto(6);

    // asynchronous reset in the middle of READ
    gen = 8; h = '0; h.vs1_hit = 8'h01;
    issue(4'b1111, 5'd1, 5'd2, 5'd3, h);
    exp_rd(1, 0, 1); exp_rd(1, 1, 2);
    goto(2); rst_n = 1'b0;
    @(negedge clk);
    chk("rstmid_valid", opn_valid, 0);
    chk("rstmid_rd_en", vrf_rd_en, 0);
    goto(3); rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid_ready", uop_ready, 1);
    chk("rstmid_opn_valid", opn_valid, 0);
    chk("rstmid_byp", vrf_byp, 0);
    chk("rstmid_hits", raw_uop_rob_q, 0);
    goto(4);

    // recovery after reset
    gen = 9; h = '0;
    issue(4'b0011, 5'd5, 5'd9, 5'd3, h);
    exp_rd(1, 0, 5); exp_rd(1, 1, 9);
    e = '0; e.vs1 = vdata(5, 9); e.vs2 = vdata(9, 9);
    exp_fire(3, e, h);
    goto(8);

    chk("rd_queue_empty", rq.size(), 0);
    chk("fire_queue_empty", fq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
